// File: rtl/retire_trace_probe_if.sv
// Trace record channel from the retirement probe to a checker.
// The probe drives records with a valid/ready handshake; the checker drives ready.
interface retire_trace_probe_if #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              trace_valid;
  logic              trace_ready;
  logic [PC_W-1:0]   trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [1:0]        trace_kind;

  modport master (
    output trace_valid, trace_pc, trace_addr, trace_data, trace_kind,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_addr, trace_data, trace_kind,
    output trace_ready
  );
endinterface

// File: rtl/retire_trace_probe.sv
// Passive retirement probe: samples stage-2 state on the core's advance strobe,
// delays it LAT stages to retirement and queues trace records in a FWFT FIFO.
module retire_trace_probe #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_ready_i,
  input  logic                 data_ready_i,
  input  logic                 data_read_i,
  input  logic                 data_write_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 ovf_clr_i,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     retire_cnt_o,
  retire_trace_probe_if.master trace
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [1:0]        kind;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [PC_W-1:0]   pc;
  } rec_t;

  logic mem;
  logic adv;
  rec_t sample;

  // Stall qualification mirrors the core: memory ops wait on data_ready.
  always_comb begin
    sample = '0;
    mem    = data_read_i | data_write_i;
    adv    = mem ? data_ready_i : inst_ready_i;
    sample.pc = pc_i;
    if (mem) begin
      sample.addr = addr_i;
      sample.data = data_i;
    end
    if (data_write_i)     sample.kind = 2'b10;
    else if (data_read_i) sample.kind = 2'b01;
  end

  logic [LAT-1:0] stg_vld_q;
  rec_t           stg_rec_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q <= '0;
      for (int i = 0; i < LAT; i++) stg_rec_q[i] <= '0;
    end else begin
      stg_vld_q[0] <= adv;
      stg_rec_q[0] <= sample;
      for (int i = 1; i < LAT; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_rec_q[i] <= stg_rec_q[i-1];
      end
    end
  end

  logic          push;
  rec_t          push_rec;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          empty, full, pop, do_write, drop;
  rec_t          fifo_q [DEPTH];
  rec_t          head;

  assign push     = stg_vld_q[LAT-1];
  assign push_rec = stg_rec_q[LAT-1];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = !empty && trace.trace_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push)     cnt_d    = cnt_q + CNT_ONE;
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clr_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) fifo_q[wr_ptr_q[AW-1:0]] <= push_rec;
  end

  assign head = fifo_q[rd_ptr_q[AW-1:0]];

  assign trace.trace_valid = !empty;
  assign trace.trace_pc    = empty ? '0 : head.pc;
  assign trace.trace_addr  = empty ? '0 : head.addr;
  assign trace.trace_data  = empty ? '0 : head.data;
  assign trace.trace_kind  = empty ? '0 : head.kind;
  assign overflow_o        = overflow_q;
  assign retire_cnt_o      = cnt_q;

endmodule
